// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing constants, RGB565 layout and timing bundle type
package vga_pkg;

    localparam int CNT_W = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int PIX_W = R_W + G_W + B_W;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic hactive;
        logic vactive;
        logic frame_start;
    } timing_t;

    function automatic logic [R_W-1:0] pix_red(input logic [PIX_W-1:0] p);
        return p[PIX_W-1 -: R_W];
    endfunction

    function automatic logic [G_W-1:0] pix_green(input logic [PIX_W-1:0] p);
        return p[B_W +: G_W];
    endfunction

    function automatic logic [B_W-1:0] pix_blue(input logic [PIX_W-1:0] p);
        return p[B_W-1:0];
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// rtl/vga_delay_line.sv - fixed-depth shift register with async clear to a reset pattern
module vga_delay_line #(
    parameter int          W       = 1,
    parameter int          DEPTH   = 2,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         pclk,
    input  logic         reset_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] pre,
    output logic [W-1:0] q
);

    logic [W-1:0] stage [DEPTH];

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    // pre is one stage short of q; lets the caller register data alongside q
    assign pre = stage[DEPTH-2];
    assign q   = stage[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA counters, pixel-fetch requests and aligned sync/RGB565 output
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int PIPE     = 2
) (
    input  logic             pclk,
    input  logic             reset_n,
    output logic             pix_req,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    input  logic [PIX_W-1:0] pix_data,
    output logic             hsync,
    output logic             vsync,
    output logic             hactive,
    output logic             vactive,
    output logic [R_W-1:0]   red,
    output logic [G_W-1:0]   green,
    output logic [B_W-1:0]   blue,
    output logic             frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    generate
        if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL || PIPE < 1) begin : g_bad_params
            $error("vga_timing_gen: totals must be <= 1024 and PIPE >= 1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_FIRST   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST    = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST    = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    localparam timing_t TIM_RST = '{hsync: ~SYNC_POL, vsync: ~SYNC_POL,
                                    hactive: 1'b0, vactive: 1'b0, frame_start: 1'b0};

    logic [CNT_W-1:0] hcnt, vcnt;
    logic             h_act, v_act;
    timing_t          tim_now, tim_pre, tim_out;
    logic [PIX_W-1:0] rgb_q;

    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    assign h_act   = (hcnt <= H_ACT_LAST);
    assign v_act   = (vcnt <= V_ACT_LAST);
    assign pix_req = h_act & v_act;
    assign pix_x   = pix_req ? hcnt : '0;
    assign pix_y   = pix_req ? vcnt : '0;

    always_comb begin
        tim_now             = TIM_RST;
        tim_now.hsync       = (hcnt >= HS_FIRST && hcnt <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        tim_now.vsync       = (vcnt >= VS_FIRST && vcnt <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        tim_now.hactive     = h_act;
        tim_now.vactive     = v_act;
        tim_now.frame_start = (hcnt == '0) && (vcnt == '0);
    end

    vga_delay_line #(
        .W       ($bits(timing_t)),
        .DEPTH   (PIPE + 1),
        .RST_VAL (TIM_RST)
    ) u_delay (
        .pclk    (pclk),
        .reset_n (reset_n),
        .d       (tim_now),
        .pre     (tim_pre),
        .q       (tim_out)
    );

    // Source data for a request arrives PIPE cycles later, aligned with tim_pre
    always_ff @(posedge pclk or negedge reset_n) begin
        if (!reset_n) rgb_q <= '0;
        else          rgb_q <= (tim_pre.hactive & tim_pre.vactive) ? pix_data : '0;
    end

    assign hsync       = tim_out.hsync;
    assign vsync       = tim_out.vsync;
    assign hactive     = tim_out.hactive;
    assign vactive     = tim_out.vactive;
    assign frame_start = tim_out.frame_start;
    assign red         = pix_red(rgb_q);
    assign green       = pix_green(rgb_q);
    assign blue        = pix_blue(rgb_q);

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized scoreboard bench for vga_timing_gen on a small raster
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 4;
    localparam int VA = 5, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam bit POL  = 1'b0;
    localparam int PIPE = 3;
    localparam int N_CYC = 1000;

    logic        pclk = 1'b0;
    logic        reset_n;
    logic        pix_req;
    logic [9:0]  pix_x, pix_y;
    logic [15:0] pix_data;
    logic        hsync, vsync, hactive, vactive, frame_start;
    logic [4:0]  red, blue;
    logic [5:0]  green;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
        .SYNC_POL (POL), .PIPE (PIPE)
    ) dut (
        .pclk        (pclk),
        .reset_n     (reset_n),
        .pix_req     (pix_req),
        .pix_x       (pix_x),
        .pix_y       (pix_y),
        .pix_data    (pix_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .hactive     (hactive),
        .vactive     (vactive),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .frame_start (frame_start)
    );

    always #5 pclk = ~pclk;

    typedef struct {
        int          cyc;
        logic        req;
        logic [9:0]  x, y;
        logic        hs, vs, ha, va, fs;
        logic [15:0] rgb;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] tab [VA][HA];
    logic [15:0] src [PIPE+1];
    int          tests = 0;
    int          fails = 0;

    // Expected behaviour from raster arithmetic: t counts cycles since reset release
    function automatic exp_t model(input int c, input int t, input bit in_rst);
        exp_t e;
        int h, v, p, ph, pv;
        h = t % HT;
        v = (t / HT) % VT;
        e.cyc = c;
        e.req = (h < HA) && (v < VA);
        e.x   = e.req ? 10'(h) : 10'd0;
        e.y   = e.req ? 10'(v) : 10'd0;
        e.hs = !POL; e.vs = !POL; e.ha = 1'b0; e.va = 1'b0; e.fs = 1'b0; e.rgb = 16'h0;
        if (!in_rst && t >= PIPE + 1) begin
            p  = t - PIPE - 1;
            ph = p % HT;
            pv = (p / HT) % VT;
            e.hs  = (ph >= HA + HF && ph < HA + HF + HS) ? POL : !POL;
            e.vs  = (pv >= VA + VF && pv < VA + VF + VS) ? POL : !POL;
            e.ha  = ph < HA;
            e.va  = pv < VA;
            e.fs  = (ph == 0) && (pv == 0);
            e.rgb = (e.ha && e.va) ? tab[pv][ph] : 16'h0;
        end
        return e;
    endfunction

    task automatic chk(input string name, input int c, input logic [15:0] act, input logic [15:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, req);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge pclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("pix_req",     e.cyc, 16'(pix_req),     16'(e.req));
                chk("pix_x",       e.cyc, 16'(pix_x),       16'(e.x));
                chk("pix_y",       e.cyc, 16'(pix_y),       16'(e.y));
                chk("hsync",       e.cyc, 16'(hsync),       16'(e.hs));
                chk("vsync",       e.cyc, 16'(vsync),       16'(e.vs));
                chk("hactive",     e.cyc, 16'(hactive),     16'(e.ha));
                chk("vactive",     e.cyc, 16'(vactive),     16'(e.va));
                chk("frame_start", e.cyc, 16'(frame_start), 16'(e.fs));
                chk("rgb",         e.cyc, {red, green, blue}, e.rgb);
            end
        end
    end

    initial begin : driver
        int t, rst_at, rst_len;
        bit release_now;
        reset_n  = 1'b0;
        pix_data = 16'h0;
        t        = 0;
        for (int v = 0; v < VA; v++)
            for (int h = 0; h < HA; h++)
                tab[v][h] = 16'($urandom);
        for (int k = 0; k <= PIPE; k++) src[k] = 16'hFFFF;
        rst_at  = $urandom_range(350, 550);
        rst_len = $urandom_range(1, 5);

        for (int c = 0; c < N_CYC; c++) begin
            @(posedge pclk);
            #1;
            release_now = 1'b0;
            if (c == rst_at) reset_n = 1'b0;
            if (c == 3 || c == rst_at + rst_len) begin
                reset_n     = 1'b1;
                release_now = 1'b1;
            end
            if (!reset_n || release_now) t = 0;
            else                         t++;
            #1;
            for (int k = PIPE; k > 0; k--) src[k] = src[k-1];
            if (pix_req && pix_x < HA && pix_y < VA)
                src[0] = tab[pix_y][pix_x];
            else
                src[0] = ($urandom_range(0, 1) == 1) ? 16'hFFFF : 16'($urandom);
            pix_data = src[PIPE];
            sb.push_back(model(c, t, !reset_n));
        end
        @(negedge pclk);
        #1;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
